// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the arbitrated ALU slice.
//   DATA_W / CTRL_W : operand and control-code widths
//   ALU_*           : 3-bit ALU control codes (010 and 110 are unused)
//   req_id_t        : requester index (1 bit)
//   slot_state_e    : output slot state (EMPTY / FULL)
//   alu_req_t       : operation payload presented by a requester
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SLL = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b111;

  typedef logic req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } alu_req_t;

endpackage

// File: rtl/alu_arb_alu.sv
// alu_arb_alu: purely combinational 32-bit ALU, no flags, arithmetic wraps.
//   i_ctrl     : control code (alu_pkg::ALU_*); unused codes yield 0
//   i_op1      : operand 1
//   i_op2      : operand 2 (low 5 bits are the shift amount for SLL)
//   o_result_c : combinational result
module alu_arb_alu
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  output logic [DATA_W-1:0] o_result_c
);

  // Operation decode
  always_comb begin
    o_result_c = '0;
    case (i_ctrl)
      ALU_ADD: o_result_c = i_op1 + i_op2;
      ALU_SUB: o_result_c = i_op1 - i_op2;
      ALU_OR:  o_result_c = i_op1 | i_op2;
      ALU_XOR: o_result_c = i_op1 ^ i_op2;
      ALU_SLL: o_result_c = i_op1 << i_op2[SHAMT_W-1:0];
      ALU_AND: o_result_c = i_op1 & i_op2;
      default: o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU; one-entry registered result slot.
//   clk_i, rst_ni              : clock, async active-low reset
//   reqN_valid_i/reqN_ready_o  : requester N handshake (ready is combinational)
//   reqN_op1_i/op2_i/ctrl_i    : requester N operation
//   rsp_valid_o/rsp_ready_i    : result slot handshake
//   rsp_id_o, rsp_data_o       : requester index and ALU result of held result
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority.
module alu_arb
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic              w_free;
  logic              w_accept;
  logic              w_any_valid;
  req_id_t           w_gnt_id;
  req_id_t           r_id;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_alu_result;
  alu_req_t          w_req0;
  alu_req_t          w_req1;
  alu_req_t          w_alu_req;

  assign w_any_valid = req0_valid_i | req1_valid_i;

`ifdef ALU_ARB_RR_EN
  req_id_t r_last;

  // Round-robin: on contention favour the requester not granted last
  always_comb begin
    w_gnt_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_gnt_id = ~r_last;
    end else if (req1_valid_i) begin
      w_gnt_id = 1'b1;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid
  always_comb begin
    w_gnt_id = 1'b0;
    if (!req0_valid_i && req1_valid_i) begin
      w_gnt_id = 1'b1;
    end
  end
`endif

  // Operand steering; defaults to requester 0 when nothing is granted
  assign w_req0    = '{ctrl: req0_ctrl_i, op1: req0_op1_i, op2: req0_op2_i};
  assign w_req1    = '{ctrl: req1_ctrl_i, op1: req1_op1_i, op2: req1_op2_i};
  assign w_alu_req = (w_gnt_id == 1'b1) ? w_req1 : w_req0;

  alu_arb_alu u_alu (
    .i_ctrl     (w_alu_req.ctrl),
    .i_op1      (w_alu_req.op1),
    .i_op2      (w_alu_req.op2),
    .o_result_c (w_alu_result)
  );

  // Slot FSM next state and combinational grant/ready
  always_comb begin
    w_state_nxt  = r_state;
    w_free       = 1'b0;
    w_accept     = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;

    w_free = (r_state == ST_EMPTY) || rsp_ready_i;
    // rst_ni gating keeps both readies low while reset is asserted
    w_accept     = rst_ni && w_free && w_any_valid;
    req0_ready_o = w_accept && (w_gnt_id == 1'b0);
    req1_ready_o = w_accept && (w_gnt_id == 1'b1);

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (rsp_ready_i && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State and result registers; result captured only on accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data <= w_alu_result;
        r_id   <= w_gnt_id;
      end
    end
  end

  assign rsp_valid_o = (r_state == ST_FULL);
  assign rsp_data_o  = r_data;
  assign rsp_id_o    = r_id;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed self-checking bench for alu_arb.
// Expected ids under contention follow ALU_ARB_RR_EN when defined.
module tb_alu_arb;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_op1_i, req0_op2_i;
  logic [2:0]  req0_ctrl_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_op1_i, req1_op2_i;
  logic [2:0]  req1_ctrl_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [31:0] rsp_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  alu_arb dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_op1_i   (req0_op1_i),
    .req0_op2_i   (req0_op2_i),
    .req0_ctrl_i  (req0_ctrl_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_op1_i   (req1_op1_i),
    .req1_op2_i   (req1_op2_i),
    .req1_ctrl_i  (req1_ctrl_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o)
  );

  task automatic test_reset();
    rst_ni = 1'b0; rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b000; req0_op1_i = 32'd1; req0_op2_i = 32'd1;
    req1_valid_i = 1'b1; req1_ctrl_i = 3'b000; req1_op1_i = 32'd2; req1_op2_i = 32'd2;
    repeat (2) @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", rsp_id_o); end
    checks++; if (req0_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready_o); end
    checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready_o); end
    rst_ni = 1'b1;
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL reset_first_ready0: got %b want 1", req0_ready_o); end
    checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_first_ready1: got %b want 0", req1_ready_o); end
    @(negedge clk_i);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b want 1", rsp_valid_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_first_id: got %b want 0", rsp_id_o); end
    checks++; if (rsp_data_o !== 32'd2) begin errors++; $display("FAIL reset_first_data: got %h want 2", rsp_data_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_drain_valid: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_single();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b000; req0_op1_i = 32'd5; req0_op2_i = 32'd7;
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b want 1", req0_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency: got %b want 0", rsp_valid_o); end
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'd12) begin errors++; $display("FAIL single_data: got %h want c", rsp_data_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rsp_id_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'd12) begin errors++; $display("FAIL single_hold_data: got %h want c", rsp_data_o); end
  endtask

  // Requester 1 alone, covering each control code, wrap and unused code
  task automatic test_ops();
    logic [2:0]  c  [6] = '{3'b011, 3'b110, 3'b101, 3'b000, 3'b111, 3'b001};
    logic [31:0] a  [6] = '{32'hA0, 32'hFF, 32'h1, 32'hFFFF_FFFF, 32'hF0F, 32'h3};
    logic [31:0] b  [6] = '{32'h0B, 32'hFF, 32'h4, 32'h1, 32'h0FF, 32'h5};
    logic [31:0] e  [6] = '{32'hAB, 32'h0, 32'h10, 32'h0, 32'h00F, 32'hFFFF_FFFE};
    rsp_ready_i = 1'b1;
    req0_ctrl_i = 3'b000; req0_op1_i = 32'h5555_0000; req0_op2_i = 32'h0000_5555;
    for (int i = 0; i < 6; i++) begin
      req1_valid_i = 1'b1; req1_ctrl_i = c[i]; req1_op1_i = a[i]; req1_op2_i = b[i];
      #1;
      checks++; if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin errors++; $display("FAIL ops_ready[%0d]: got r0=%b r1=%b want r0=0 r1=1", i, req0_ready_o, req1_ready_o); end
      @(negedge clk_i);
      req1_valid_i = 1'b0;
      checks++; if (rsp_data_o !== e[i]) begin errors++; $display("FAIL ops_data[%0d]: got %h want %h", i, rsp_data_o, e[i]); end
      checks++; if (rsp_id_o !== 1'b1 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL ops_id[%0d]: got id=%b v=%b want id=1 v=1", i, rsp_id_o, rsp_valid_o); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_contention();
    logic        exp_id;
    logic [31:0] exp_data;
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b001; req0_op1_i = 32'd10;  req0_op2_i = 32'd3;
    req1_valid_i = 1'b1; req1_ctrl_i = 3'b100; req1_op1_i = 32'hF0;  req1_op2_i = 32'h0F;
    #1;
    checks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL cont_first_grant: got r0=%b r1=%b want r0=1 r1=0", req0_ready_o, req1_ready_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      exp_id   = RR ? 1'(i % 2) : 1'b0;
      exp_data = exp_id ? 32'hFF : 32'd7;
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL cont_valid[%0d]: got %b want 1", i, rsp_valid_o); end
      checks++; if (rsp_id_o !== exp_id) begin errors++; $display("FAIL cont_id[%0d]: got %b want %b", i, rsp_id_o, exp_id); end
      checks++; if (rsp_data_o !== exp_data) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, rsp_data_o, exp_data); end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b000; req0_op1_i = 32'd1; req0_op2_i = 32'd2;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_ctrl_i = 3'b001; req1_op1_i = 32'd7; req1_op2_i = 32'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready1[%0d]: got %b want 0", i, req1_ready_o); end
      checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd3 || rsp_id_o !== 1'b0) begin errors++; $display("FAIL bp_stable[%0d]: got v=%b d=%h id=%b want v=1 d=3 id=0", i, rsp_valid_o, rsp_data_o, rsp_id_o); end
      req1_op1_i = 32'(40 + i);
      @(negedge clk_i);
    end
    req1_op1_i = 32'd100; req1_op2_i = 32'd1;
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready1: got %b want 1", req1_ready_o); end
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd99 || rsp_id_o !== 1'b1) begin errors++; $display("FAIL bp_new_result: got v=%b d=%h id=%b want v=1 d=63 id=1", rsp_valid_o, rsp_data_o, rsp_id_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_mid_reset();
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_ctrl_i = 3'b000; req0_op1_i = 32'h1000; req0_op2_i = 32'h234;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h1234) begin errors++; $display("FAIL mrst_loaded: got v=%b d=%h want v=1 d=1234", rsp_valid_o, rsp_data_o); end
    rst_ni = 1'b0; req1_valid_i = 1'b1; req1_ctrl_i = 3'b000; req1_op1_i = 32'd9; req1_op2_i = 32'd9;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid_now: got %b want 0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'd0) begin errors++; $display("FAIL mrst_data_now: got %h want 0", rsp_data_o); end
    checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL mrst_ready1: got %b want 0", req1_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_after[%0d]: got %b want 0", i, rsp_valid_o); end
    end
  endtask

  initial begin
    rst_ni = 1'b0; rsp_ready_i = 1'b0;
    req0_valid_i = 1'b0; req0_op1_i = '0; req0_op2_i = '0; req0_ctrl_i = '0;
    req1_valid_i = 1'b0; req1_op1_i = '0; req1_op2_i = '0; req1_ctrl_i = '0;
    test_reset();
    test_single();
    test_ops();
    test_contention();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
